// File: rtl/clockworks_pkg.sv
// Shared types and helpers for the clock/reset sequencer slice.
package clockworks_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_STAGE,
    ST_RUN
  } state_t;

  localparam int unsigned HOLD_CYCLES_DEF     = 65535;
  localparam int unsigned STAGE_GAP_DEF       = 16;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;

  // Width of a counter that must be able to hold the value n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: programmable divider with single-step override.
module ce_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             hold,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;

  // While idle or held the divide value keeps tracking the input, so it is
  // freshly latched on the edge that (re)starts counting.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      div_q <= '0;
      ce    <= 1'b0;
    end else if (!run || hold) begin
      cnt_q <= '0;
      div_q <= div;
      ce    <= run && hold && step;
    end else if (cnt_q == div_q) begin
      cnt_q <= '0;
      div_q <= div;
      ce    <= 1'b1;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
      ce    <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_reset_sequencer.sv
// Staged reset release, per-channel clock-enable dividers and single-step mode.
// Optional step_i debounce filter: define CLOCKWORKS_STEP_DEBOUNCE_EN.
module clock_reset_sequencer
  import clockworks_pkg::*;
#(
  parameter int unsigned NCH             = 4,
  parameter int unsigned DIV_W           = 16,
  parameter int unsigned NRST            = 2,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned STAGE_GAP       = STAGE_GAP_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NCH*DIV_W-1:0] div_i,
  input  logic                 step_mode_i,
  input  logic                 step_i,
  output logic [NRST-1:0]      resetn_o,
  output logic [NCH-1:0]       ce_o,
  output logic                 ready_o
);

  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int unsigned GAP_W  = cnt_w(STAGE_GAP);

  if (NCH < 1 || NRST < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("clock_reset_sequencer: parameter out of range");
  end

  logic rst_meta;
  logic rst_int;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  logic step_meta;
  logic step_sync;
  logic step_lvl;
  logic step_prev;
  logic step_rise;

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_meta <= step_i;
      step_sync <= step_meta;
      step_prev <= step_lvl;
    end
  end

`ifdef CLOCKWORKS_STEP_DEBOUNCE_EN
  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);

  logic [DB_W-1:0] db_cnt_q;
  logic            db_q;

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (step_sync == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_q     <= step_sync;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  always_comb step_lvl = db_q;
`else
  always_comb step_lvl = step_sync;
`endif

  always_comb step_rise = step_lvl && !step_prev;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [NRST-1:0]   rstn_q, rstn_d;

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rstn_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rstn_q     <= rstn_d;
    end
  end

  // Stages release strictly in order, so shifting a 1 in from bit 0 is
  // equivalent to tracking a stage index.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rstn_d     = rstn_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
          rstn_d  = NRST'(1);
          state_d = (NRST == 1) ? ST_RUN : ST_STAGE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_STAGE: begin
        if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
          gap_cnt_d = '0;
          rstn_d    = (rstn_q << 1) | NRST'(1);
          if (rstn_d[NRST-1]) state_d = ST_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HOLD;
    endcase
  end

  logic run;

  always_comb begin
    run      = (state_q == ST_RUN);
    ready_o  = run;
    resetn_o = rstn_q;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ce_divider #(
      .DIV_W(DIV_W)
    ) u_div (
      .CLK  (CLK),
      .RESET(rst_int),
      .run  (run),
      .hold (step_mode_i),
      .step (step_rise),
      .div  (div_i[c*DIV_W +: DIV_W]),
      .ce   (ce_o[c])
    );
  end

endmodule
